reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of a 32-bit register (Reg32 interface: regWrite/writeData) between 4 requesters.
- Grants bounded bursts of back-to-back writes, one word per cycle, with a per-word acknowledge.
- Sits between producer units (ALU result, load unit, PC logic, debug) and the shared register.

Parameters:
DATA_WIDTH, 32, width of each write word and of writeData
MAX_BURST, 4, max consecutive writes per grant before the owner must yield (legal 1..15; 1 = pure round-robin)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state at the rising edge where it is high
req  input  4  per-requester write request, bit i for requester i; held high while requester has words to write
wdata  input  4*DATA_WIDTH  requester i word on bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  output  4  one-hot pulse, one cycle per word accepted; asserted in the same cycle the word is on writeData
regWrite  output  1  write enable to the register, registered
writeData  output  DATA_WIDTH  write word to the register, registered
owner  output  2  index of current/last granted requester
busy  output  1  high while in BURST state

Behaviour:
- Reset (synchronous): regWrite=0, writeData=0, ack=0, owner=0, busy=0, rr pointer ptr=0, burst count cnt=0, state=IDLE. Reset mid-burst aborts at that edge: no regWrite/ack in the following cycle. The word acked in the reset cycle itself still counts as written.
- Arbitration function: scan req starting at index ptr, wrapping 3->0; the first set bit wins.
- Word transfer at edge k: winner w's wdata is sampled. In cycle k..k+1: regWrite=1, writeData=sampled word, ack=(1<<w), owner=w. Latency request->write is 1 cycle.
- Requester protocol: hold req and the current word until that word's ack. During an ack cycle, either present the next word (keep req high) or drop req if that was the last word. The arbiter never samples wdata of a non-winner.
- State IDLE, at edge:
  - req==0: stay IDLE, regWrite=0, ack=0.
  - otherwise: winner w, transfer, state=BURST, cnt=1.
- State BURST (owner w), at edge:
  - req[w]==1 and cnt<MAX_BURST: transfer from w again, cnt=cnt+1, ptr unchanged.
  - otherwise: ptr=(w+1) mod 4, then arbitrate in the same edge using the new ptr.
    - If any req: transfer from the new winner, cnt=1. The new winner may be w itself if it is the only requester. No bubble cycle.
    - If req==0: state=IDLE, regWrite=0, ack=0.
- busy=1 exactly in cycles where state=BURST (coincides with regWrite=1).
- ptr updates only on yield. A requester dropping req mid-burst yields immediately.
- Requests arriving during another owner's burst wait. Worst-case wait = 3*MAX_BURST cycles (starvation-free).
- cnt is 4 bits and never exceeds MAX_BURST; no wrap.
- wdata of non-requesting lanes is ignored. req bits changing outside the owner lane affect only the next arbitration.

Test Plan:
- Reset, then req=0 for 5 cycles -> regWrite=0, ack=0, writeData=0, busy=0 every cycle.
- req=4'b0001 once, wdata0=32'hffffffff, drop req on ack -> exactly one cycle regWrite=1, writeData=32'hffffffff, ack=4'b0001; IDLE next cycle.
- req0 held for 6 words 32'h1..32'h6, MAX_BURST=4 -> writes 1,2,3,4, then yield re-grants 0 with no bubble: writes 5,6; 6 acks total in 6 consecutive cycles.
- req=4'b1111 held, each lane constant (0xA0,0xB1,0xC2,0xD3), MAX_BURST=4 -> 4 writes each in order 0,1,2,3,0,... with owner changing every 4 cycles.
- req0 and req2 both held, MAX_BURST=1 -> writeData alternates lane0/lane2 every cycle; ack alternates 4'b0001/4'b0100.
- Mid-burst reset pulse (1 cycle) during lane1 word 2 -> next cycle regWrite=0, ack=0, ptr=0. With req1 still high, lane1 is re-granted 1 cycle after reset deasserts.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one 32-bit register write port (regWrite/writeData)
// between four requesters. Each grant is a burst of up to MAX_BURST back-to-back
// words, one per cycle, each acknowledged by a one-hot ack pulse that coincides
// with the word appearing on writeData.
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                req,
    input  logic [4*DATA_WIDTH-1:0]   wdata,
    output logic [3:0]                ack,
    output logic                      regWrite,
    output logic [DATA_WIDTH-1:0]     writeData,
    output logic [1:0]                owner,
    output logic                      busy
);

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_BURST = 1'b1;

    // Burst length limit in the counter's own width; legal values fit in 4 bits.
    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    logic       state;
    logic [1:0] ptr;
    logic [3:0] cnt;

    logic                  keepOwner;
    logic [1:0]            scanStart;
    logic [2:0]            pick;
    logic                  grantValid;
    logic [1:0]            grantIdx;
    logic [1:0]            nextPtr;
    logic [3:0]            nextCnt;
    logic [DATA_WIDTH-1:0] selWord;

    // Returns {found, index} of the first set request bit at or after start,
    // wrapping 3->0. Scanning from the far end lets the nearest hit win.
    function automatic logic [2:0] pickWinner(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Decide the next word's source: continue the current burst, or yield and
    // re-arbitrate from the lane after the owner in the same cycle (no bubble).
    always_comb begin
        keepOwner  = (state == STATE_BURST) && req[owner] && (cnt < MAX_CNT);
        scanStart  = (state == STATE_BURST) ? owner + 2'd1 : ptr;
        pick       = pickWinner(req, scanStart);
        nextPtr    = ((state == STATE_BURST) && !keepOwner) ? owner + 2'd1 : ptr;
        grantValid = keepOwner || pick[2];
        grantIdx   = keepOwner ? owner : pick[1:0];
        nextCnt    = keepOwner ? cnt + 4'd1 : 4'd1;
        case (grantIdx)
            2'd0:    selWord = wdata[0*DATA_WIDTH +: DATA_WIDTH];
            2'd1:    selWord = wdata[1*DATA_WIDTH +: DATA_WIDTH];
            2'd2:    selWord = wdata[2*DATA_WIDTH +: DATA_WIDTH];
            default: selWord = wdata[3*DATA_WIDTH +: DATA_WIDTH];
        endcase
    end

    // Output register stage: the granted word is presented with its ack one cycle after request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= STATE_IDLE;
            ptr       <= 2'd0;
            cnt       <= 4'd0;
            owner     <= 2'd0;
            regWrite  <= 1'b0;
            ack       <= 4'b0000;
            writeData <= '0;
        end else begin
            ptr <= nextPtr;
            if (grantValid) begin
                state     <= STATE_BURST;
                cnt       <= nextCnt;
                owner     <= grantIdx;
                regWrite  <= 1'b1;
                ack       <= 4'b0001 << grantIdx;
                writeData <= selWord;
            end else begin
                state    <= STATE_IDLE;
                cnt      <= 4'd0;
                regWrite <= 1'b0;
                ack      <= 4'b0000;
            end
        end
    end

    // Busy mirrors the BURST state, which is exactly the set of write cycles.
    always_comb begin
        busy = (state == STATE_BURST);
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: two instances (MAX_BURST=4 and 1) fed by
// queue-based requesters; a reference model pushes the expected response of every
// edge and a separate monitor pops and compares after each rising edge.
module tb_reg_write_arbiter;

    localparam int DW = 32;

    typedef struct {
        logic        rw;
        logic [31:0] data;
        logic [3:0]  ack;
        logic [1:0]  own;
        logic        busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req0 = '0, req1 = '0;
    logic [127:0] wdata0 = '0, wdata1 = '0;
    logic [3:0]   ack0, ack1;
    logic         regWrite0, regWrite1;
    logic [31:0]  writeData0, writeData1;
    logic [1:0]   owner0, owner1;
    logic         busy0, busy1;

    // Per-requester pending words: index d*4+lane.
    logic [31:0] lq[8][$];
    exp_t        expQ0[$];
    exp_t        expQ1[$];

    // Reference model state (per instance).
    int          mBusy[2];
    int          mOwner[2];
    int          mCnt[2];
    int          mPtr[2];
    int          mLast[2];
    logic [31:0] mData[2];

    int   nChecks = 0;
    int   nFails  = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(4)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .wdata(wdata0), .ack(ack0),
        .regWrite(regWrite0), .writeData(writeData0), .owner(owner0), .busy(busy0)
    );

    reg_write_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .wdata(wdata1), .ack(ack1),
        .regWrite(regWrite1), .writeData(writeData1), .owner(owner1), .busy(busy1)
    );

    // Reference: the owner keeps the port while it still requests and has burst
    // budget left; otherwise the port goes to the first requester after the owner.
    task automatic modelEdge(input int d, input logic rs, input logic [3:0] r, input logic [127:0] wd);
        exp_t e;
        int   mb;
        int   w;
        mb = (d == 0) ? 4 : 1;
        w  = -1;
        if (rs) begin
            mBusy[d] = 0; mOwner[d] = 0; mCnt[d] = 0; mPtr[d] = 0; mLast[d] = -1; mData[d] = '0;
        end else begin
            if (mBusy[d] != 0 && r[mOwner[d]] && mCnt[d] < mb) begin
                w = mOwner[d];
                mCnt[d] = mCnt[d] + 1;
            end else begin
                if (mBusy[d] != 0) mPtr[d] = (mOwner[d] + 1) % 4;
                for (int k = 0; k < 4; k++) begin
                    if (w < 0 && r[(mPtr[d] + k) % 4]) w = (mPtr[d] + k) % 4;
                end
                if (w >= 0) mCnt[d] = 1;
            end
            mLast[d] = w;
            if (w >= 0) begin
                mBusy[d]  = 1;
                mOwner[d] = w;
                mData[d]  = wd[w*32 +: 32];
            end else begin
                mBusy[d] = 0;
            end
        end
        e.rw   = (w >= 0);
        e.data = mData[d];
        e.ack  = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        e.own  = 2'(mOwner[d]);
        e.busy = (w >= 0);
        if (d == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endtask

    // One cycle of requester behaviour followed by the model's view of the next edge.
    task automatic step(input logic rs);
        logic [3:0]   r;
        logic [127:0] wd;
        for (int d = 0; d < 2; d++) begin
            if (mLast[d] >= 0) void'(lq[d*4 + mLast[d]].pop_front());
        end
        reset = rs;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                r[i] = (lq[d*4+i].size() > 0);
                wd[i*32 +: 32] = r[i] ? lq[d*4+i][0] : $urandom();
            end
            if (d == 0) begin req0 = r; wdata0 = wd; end
            else        begin req1 = r; wdata1 = wd; end
            modelEdge(d, rs, r, wd);
        end
        started = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic pushWords(input int d, input int lane, input logic [31:0] first, input int n, input int incr);
        for (int k = 0; k < n; k++) lq[d*4 + lane].push_back(first + 32'(k * incr));
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int q = 0; q < 8; q++) s += lq[q].size();
        return s;
    endfunction

    task automatic checkOne(input int d, input exp_t e, input logic rw, input logic [31:0] dat,
                            input logic [3:0] a, input logic [1:0] own, input logic b);
        nChecks++;
        if (rw !== e.rw || dat !== e.data || a !== e.ack || own !== e.own || b !== e.busy) begin
            nFails++;
            $display("FAIL port%0d t=%0t got rw=%b data=%h ack=%b owner=%0d busy=%b, want rw=%b data=%h ack=%b owner=%0d busy=%b",
                     d, $time, rw, dat, a, own, b, e.rw, e.data, e.ack, e.own, e.busy);
        end
    endtask

    // Monitor: compare each instance's outputs against the scoreboard just after every edge.
    always @(posedge clk) begin
        #1;
        if (started) begin
            if (expQ0.size() == 0 || expQ1.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL scoreboard_empty t=%0t sizes %0d/%0d, want nonzero", $time, expQ0.size(), expQ1.size());
            end else begin
                checkOne(0, expQ0.pop_front(), regWrite0, writeData0, ack0, owner0, busy0);
                checkOne(1, expQ1.pop_front(), regWrite1, writeData1, ack1, owner1, busy1);
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            mBusy[d] = 0; mOwner[d] = 0; mCnt[d] = 0; mPtr[d] = 0; mLast[d] = -1; mData[d] = '0;
        end

        // Reset, then idle.
        repeat (3) step(1'b1);
        repeat (5) step(1'b0);

        // Single word of all ones from lane 0.
        pushWords(0, 0, 32'hffffffff, 1, 0);
        repeat (3) step(1'b0);

        // Six words from lane 0: burst of 4, then an immediate re-grant.
        pushWords(0, 0, 32'h1, 6, 1);
        repeat (8) step(1'b0);

        // All four lanes requesting constant words on instance 0; lanes 0 and 2 on instance 1.
        pushWords(0, 0, 32'hA0, 8, 0);
        pushWords(0, 1, 32'hB1, 8, 0);
        pushWords(0, 2, 32'hC2, 8, 0);
        pushWords(0, 3, 32'hD3, 8, 0);
        pushWords(1, 0, 32'h100, 6, 1);
        pushWords(1, 2, 32'h200, 6, 1);
        repeat (36) step(1'b0);

        // Reset during lane 1's second word; lane 1 keeps requesting afterwards.
        pushWords(0, 1, 32'h11, 5, 1);
        pushWords(1, 1, 32'h21, 5, 1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        repeat (8) step(1'b0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 3) == 0) begin
                    int lane;
                    lane = $urandom_range(0, 3);
                    if (lq[d*4 + lane].size() < 6) pushWords(d, lane, $urandom(), $urandom_range(1, 5), 1);
                end
            end
            step($urandom_range(0, 199) == 0);
        end

        // Drain outstanding words.
        for (int c = 0; c < 400 && pending() > 0; c++) step(1'b0);
        nChecks++;
        if (pending() != 0) begin
            nFails++;
            $display("FAIL drain words_left=%0d, want 0", pending());
        end
        step(1'b0);
        nChecks++;
        if (expQ0.size() != 0 || expQ1.size() != 0) begin
            nFails++;
            $display("FAIL scoreboard_left sizes %0d/%0d, want 0/0", expQ0.size(), expQ1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
